// File: rtl/moving_average_n_pkg.sv
// moving_average_pkg: shared types, default sizes and window clamping for the moving-average filter
package moving_average_pkg;
    localparam int DEF_DATA_W   = 8;
    localparam int DEF_MAX_LOG2 = 3;
    localparam int DEF_SEL_W    = $clog2(DEF_MAX_LOG2 + 1);
    localparam int DEF_ACC_W    = DEF_DATA_W + DEF_MAX_LOG2 + 1;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;
    typedef logic signed [DEF_ACC_W-1:0]  acc_t;
    typedef logic        [DEF_SEL_W-1:0]  win_t;

    // Windows wider than the buffer fall back to the full buffer depth
    function automatic int clamp_win(input int sel, input int max_log2);
        return (sel > max_log2) ? max_log2 : sel;
    endfunction
endpackage

// File: rtl/moving_average_n_if.sv
// moving_average_n_if: sample stream in, averaged stream out, plus window select and clear
interface moving_average_n_if #(
    parameter int DATA_W   = 8,
    parameter int MAX_LOG2 = 3
);
    localparam int SEL_W = $clog2(MAX_LOG2 + 1);

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic [SEL_W-1:0]         win_sel;
    logic                     clear;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     primed;

    modport master (
        output in_valid, in_data, win_sel, clear,
        input  out_valid, out_data, primed
    );

    modport slave (
        input  in_valid, in_data, win_sel, clear,
        output out_valid, out_data, primed
    );
endinterface

// File: rtl/ma_delay_line.sv
// ma_delay_line: circular sample buffer whose read port shows the sample leaving an L-deep window
module ma_delay_line #(
    parameter int DATA_W   = 8,
    parameter int MAX_LOG2 = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic [MAX_LOG2-1:0]      i_len,
    output logic signed [DATA_W-1:0] o_oldest
);
    localparam int DEPTH = 2 ** MAX_LOG2;

    logic signed [DATA_W-1:0] r_buf [DEPTH];
    logic [MAX_LOG2-1:0]      r_wr_ptr;

    // Write pointer advances on every accepted sample and wraps with the buffer depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wr_ptr <= '0;
        else if (i_we) r_wr_ptr <= r_wr_ptr + MAX_LOG2'(1);
    end

    // Sample storage is never reset; the fill count keeps stale entries out of the sum
    always_ff @(posedge clk) begin
        if (i_we) r_buf[r_wr_ptr] <= i_data;
    end

    // L equal to the depth wraps to 0 here, selecting the slot about to be overwritten
    assign o_oldest = r_buf[r_wr_ptr - i_len];
endmodule

// File: rtl/moving_average_n.sv
// moving_average_n: streaming power-of-two moving average with warm-up suppression and restart
module moving_average_n
    import moving_average_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_LOG2 = DEF_MAX_LOG2
) (
    input  logic              system1000,
    input  logic              system1000_rst,
    moving_average_n_if.slave bus
);
    localparam int SEL_W = $clog2(MAX_LOG2 + 1);
    localparam int ACC_W = DATA_W + MAX_LOG2 + 1;

    logic [SEL_W-1:0]         r_win, w_win;
    logic [MAX_LOG2:0]        r_fill, w_fill, w_fill_nxt, w_len;
    logic signed [ACC_W-1:0]  r_sum, w_sum, w_sum_nxt;
    logic signed [DATA_W-1:0] w_oldest, r_out_data;
    logic                     r_out_valid, r_primed, w_restart, w_full, w_fire;

    ma_delay_line #(.DATA_W(DATA_W), .MAX_LOG2(MAX_LOG2)) u_delay (
        .clk      (system1000),
        .rst      (system1000_rst),
        .i_we     (bus.in_valid),
        .i_data   (bus.in_data),
        .i_len    (w_len[MAX_LOG2-1:0]),
        .o_oldest (w_oldest)
    );

    // Restart is applied before the incoming sample, so it becomes the first sample of the new window
    always_comb begin
        w_win      = SEL_W'(clamp_win(int'(bus.win_sel), MAX_LOG2));
        w_restart  = bus.clear || (w_win != r_win);
        w_len      = (MAX_LOG2 + 1)'(1) << w_win;
        w_fill     = w_restart ? '0 : r_fill;
        w_sum      = w_restart ? '0 : r_sum;
        w_full     = (w_fill == w_len);
        w_sum_nxt  = w_full ? w_sum + ACC_W'(bus.in_data) - ACC_W'(w_oldest)
                            : w_sum + ACC_W'(bus.in_data);
        w_fill_nxt = w_full ? w_fill : w_fill + (MAX_LOG2 + 1)'(1);
        w_fire     = bus.in_valid && (w_fill_nxt == w_len);
    end

    // Running sum, fill level, window and the one-cycle-late output register
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            r_win       <= '0;
            r_fill      <= '0;
            r_sum       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_primed    <= 1'b0;
        end else begin
            r_win       <= w_win;
            r_fill      <= bus.in_valid ? w_fill_nxt : w_fill;
            r_sum       <= bus.in_valid ? w_sum_nxt : w_sum;
            r_out_valid <= w_fire;
            r_primed    <= (r_primed && !w_restart) || w_fire;
            if (w_fire) r_out_data <= DATA_W'(w_sum_nxt >>> w_win);
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.primed    = r_primed;
endmodule

// File: tb/tb_moving_average_n.sv
// tb_moving_average_n: directed and model-checked stimulus for the moving-average filter
module tb_moving_average_n;
    import moving_average_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    moving_average_n_if #(.DATA_W(8), .MAX_LOG2(4)) bus ();

    moving_average_n #(.DATA_W(8), .MAX_LOG2(4)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .bus            (bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the capturing edge
    task automatic step(input bit v, input int d, input int ws, input bit clr);
        bus.in_valid = v;
        bus.in_data  = 8'(d);
        bus.win_sel  = 3'(ws);
        bus.clear    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input string tag, input bit v, input int d, input int ws, input bit clr,
                        input bit exp_v, input int exp_d);
        step(v, d, ws, clr);
        check({tag, "_valid"}, int'(bus.out_valid), int'(exp_v));
        if (exp_v) check({tag, "_data"}, int'(bus.out_data), exp_d);
    endtask

    initial begin
        sample_t q[$];
        bit      ever;
        int      s;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'sd5;
        bus.win_sel  = '0;
        bus.clear    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_valid", int'(bus.out_valid), 0);
            check("rst_data", int'(bus.out_data), 0);
            check("rst_primed", int'(bus.primed), 0);
        end
        rst = 1'b0;

        feed("w2_s4", 1, 4, 2, 0, 0, 0);
        feed("w2_s8", 1, 8, 2, 0, 0, 0);
        feed("w2_s12", 1, 12, 2, 0, 0, 0);
        check("w2_primed_pre", int'(bus.primed), 0);
        feed("w2_s16", 1, 16, 2, 0, 1, 10);
        check("w2_primed", int'(bus.primed), 1);
        feed("w2_s20", 1, 20, 2, 0, 1, 14);

        feed("w1_m1", 1, -1, 1, 0, 0, 0);
        check("w1_primed_restart", int'(bus.primed), 0);
        feed("w1_floor", 1, 0, 1, 0, 1, -1);
        feed("w1_127a", 1, 127, 1, 0, 1, 63);
        feed("w1_127b", 1, 127, 1, 0, 1, 127);
        feed("w1_m128a", 1, -128, 1, 0, 1, -1);
        feed("w1_m128b", 1, -128, 1, 0, 1, -128);

        feed("chg_a", 1, 1, 2, 0, 0, 0);
        feed("chg_b", 1, 1, 2, 0, 0, 0);
        feed("chg_c", 1, 1, 2, 0, 0, 0);
        feed("chg_d", 1, 1, 2, 0, 1, 1);
        feed("chg_6", 1, 6, 1, 0, 0, 0);
        check("chg_primed", int'(bus.primed), 0);
        feed("chg_2", 1, 2, 1, 0, 1, 4);

        feed("clr_w0", 1, 9, 0, 1, 1, 9);
        check("clr_w0_primed", int'(bus.primed), 1);
        feed("clr_w2", 1, 9, 2, 1, 0, 0);
        check("clr_w2_primed", int'(bus.primed), 0);
        feed("clr_w2_b", 1, 9, 2, 0, 0, 0);
        feed("clr_w2_c", 1, 9, 2, 0, 0, 0);
        feed("clr_w2_d", 1, 9, 2, 0, 1, 9);
        feed("clr_idle", 0, 0, 2, 1, 0, 0);
        check("clr_idle_primed", int'(bus.primed), 0);
        feed("clr_idle_a", 1, 1, 2, 0, 0, 0);
        feed("clr_idle_b", 1, 2, 2, 0, 0, 0);
        feed("clr_idle_c", 1, 3, 2, 0, 0, 0);
        feed("clr_idle_d", 1, 4, 2, 0, 1, 2);

        for (int i = 0; i < 16; i++)
            feed("clamp", 1, i * 3 - 20, 6, 0, i == 15, 2);
        feed("clamp_same", 1, 100, 4, 0, 1, 10);

        ever = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bit v;
            int d;
            v = ($urandom_range(3) != 0);
            d = int'($urandom_range(255)) - 128;
            step(v, d, 3, 0);
            if (v) q.push_back(8'(d));
            if (q.size() > 8) void'(q.pop_front());
            if (v && q.size() == 8) begin
                s = 0;
                foreach (q[k]) s += int'(q[k]);
                ever = 1'b1;
                check("rand_valid", int'(bus.out_valid), 1);
                check("rand_data", int'(bus.out_data), s >>> 3);
            end else begin
                check("rand_valid", int'(bus.out_valid), 0);
            end
            check("rand_primed", int'(bus.primed), int'(ever));
        end

        bus.in_valid = 1'b0;
        bus.win_sel  = '0;
        rst = 1'b1;
        #1;
        check("midrst_valid", int'(bus.out_valid), 0);
        check("midrst_data", int'(bus.out_data), 0);
        check("midrst_primed", int'(bus.primed), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        feed("post_rst", 1, 7, 0, 0, 1, 7);
        check("post_rst_primed", int'(bus.primed), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
